shift_sequencer: RTL
====================

// Module: shift_sequencer
// PURPOSE
//  Command-driven controller for the WIDTH-bit synchronous shift register (mode 00 clear,
//  01 parallel load, 10 shift left, 11 shift right; register has no hold mode and no reset).
//  Accepts {data, direction, count} commands over valid/ready, then sequences load and
//  N shifts, streaming each discarded bit out serially. Returns the final register value
//  over a valid/ready response. Sole master of the register's mode/data_in pins.
// PARAMETERS
//  WIDTH  8                   register width in bits
//  CNT_W  $clog2(WIDTH+1)     width of cmd_count
// PORTS
//  clk         in   1      clock, all logic on rising edge
//  rst_n       in   1      asynchronous active-low reset
//  cmd_valid   in   1      command present
//  cmd_ready   out  1      controller can accept command (IDLE only)
//  cmd_data    in   WIDTH  value to parallel-load
//  cmd_dir     in   1      0 = shift left (mode 10), 1 = shift right (mode 11)
//  cmd_count   in   CNT_W  number of shifts; values > WIDTH saturate to WIDTH
//  abort       in   1      synchronous abandon of current operation
//  sr_mode     out  2      mode to shift register
//  sr_data_in  out  WIDTH  parallel data to shift register
//  sr_out      in   WIDTH  shift register current contents
//  ser_bit     out  1      bit discarded by the shift occurring at the coming edge
//  ser_valid   out  1      ser_bit qualifier, high only in SHIFT cycles
//  rsp_valid   out  1      result available
//  rsp_ready   in   1      result consumer ready
//  rsp_data    out  WIDTH  register contents after final shift
//  busy        out  1      high in every state except IDLE
// BEHAVIOUR
//  - Async reset -> state CLEAR; cmd_ready=0, rsp_valid=0, ser_valid=0, sr_mode=00,
//    sr_data_in=0, busy=1, internal count/dir/data regs=0.
//  - States: CLEAR, IDLE, LOAD, SHIFT, RESP. sr_mode/sr_data_in are combinational from state.
//  - CLEAR: sr_mode=00 for exactly one cycle -> IDLE.
//  - IDLE: cmd_ready=1; sr_mode=01, sr_data_in=sr_out (recirculate = hold). On
//    cmd_valid&cmd_ready capture data/dir/saturated count -> LOAD.
//  - LOAD: sr_mode=01, sr_data_in=captured data, one cycle. count==0 -> RESP, else SHIFT.
//  - SHIFT: sr_mode = cmd_dir ? 11 : 10; ser_valid=1; ser_bit = dir ? sr_out[0] :
//    sr_out[WIDTH-1]; remaining count decrements each cycle; after last shift -> RESP.
//  - RESP: rsp_valid=1, rsp_data=sr_out, sr_mode=01 recirculate (hold); rsp_data stable
//    while rsp_ready low. On rsp_ready -> IDLE (no clear; contents retained).
//  - Latency: accept edge to rsp_valid = count+2 cycles; cmd_ready returns the cycle after
//    response handshake. One command in flight; no command accepted outside IDLE.
//  - abort (any state, incl. IDLE/RESP) -> CLEAR next edge; abort wins over simultaneous
//    cmd or rsp handshake; aborted command produces no response. Abort in CLEAR is a no-op.
//  - Reset mid-operation: immediate return to CLEAR outputs; register cleared next cycle.
//  - cmd_data/cmd_dir/cmd_count sampled only at accept; later changes ignored.
// TESTING
//  1 Reset release -> one cycle sr_mode=00, then IDLE, cmd_ready=1, sr_mode=01 holding 0x00.
//  2 cmd 0xAA, dir=0, count=3 -> ser_bit 1,0,1 with ser_valid; rsp_data=0x50 at accept+5.
//  3 cmd 0xAA, dir=1, count=3 -> ser_bit 0,1,0; rsp_data=0x15; register held 0x15 in IDLE.
//  4 count=0 -> no ser_valid, rsp_data=0xAA at accept+2; count=12 -> 8 shifts, rsp_data=0x00.
//  5 rsp_ready low 4 cycles -> rsp_valid/rsp_data stable, sr_out unchanged, cmd_ready=0.
//  6 abort during 2nd shift of 0xFF/count=5 -> next cycle sr_mode=00, no rsp, then IDLE at 0x00.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Command and response handshake bundle between a command source and the
// shift sequencer.
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_data, cmd_dir, cmd_count, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_dir, cmd_count, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/shift_sequencer.sv
// Command-driven controller for an external WIDTH-bit shift register: load,
// N shifts with the discarded bits streamed out, then a final-value response.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_sequencer_if.slave bus,
  input  logic             abort,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_data_in,
  input  logic [WIDTH-1:0] sr_out,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             busy
);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    LOAD,
    SHIFT,
    RESP
  } state_t;

  localparam logic [1:0]       MODE_CLEAR = 2'b00;
  localparam logic [1:0]       MODE_LOAD  = 2'b01;
  localparam logic [1:0]       MODE_LEFT  = 2'b10;
  localparam logic [1:0]       MODE_RIGHT = 2'b11;
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;
  logic [WIDTH-1:0] data_q;
  logic             accept;
  logic [CNT_W-1:0] sat_count;

  // Abort suppresses the ready so a simultaneous command is never seen as taken.
  assign accept    = (state_q == IDLE) && bus.cmd_valid && !abort;
  assign sat_count = (bus.cmd_count > MAX_CNT) ? MAX_CNT : bus.cmd_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q  <= sat_count;
        dir_q  <= bus.cmd_dir;
        data_q <= bus.cmd_data;
      end else if (state_q == SHIFT) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: state_d = IDLE;
      IDLE:  if (accept) state_d = LOAD;
      LOAD:  state_d = (cnt_q == '0) ? RESP : SHIFT;
      SHIFT: if (cnt_q <= CNT_W'(1)) state_d = RESP;
      RESP:  if (bus.rsp_ready) state_d = IDLE;
      default: state_d = CLEAR;
    endcase
    if (abort && state_q != CLEAR) state_d = CLEAR;
  end

  // Idle and response states recirculate the register through a parallel load,
  // since the register itself has no hold mode.
  always_comb begin
    sr_mode       = MODE_LOAD;
    sr_data_in    = sr_out;
    ser_bit       = 1'b0;
    ser_valid     = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    busy          = 1'b1;
    case (state_q)
      CLEAR: begin
        sr_mode    = MODE_CLEAR;
        sr_data_in = '0;
      end
      IDLE: begin
        bus.cmd_ready = !abort;
        busy          = 1'b0;
      end
      LOAD: begin
        sr_data_in = data_q;
      end
      SHIFT: begin
        sr_mode    = dir_q ? MODE_RIGHT : MODE_LEFT;
        sr_data_in = '0;
        ser_valid  = 1'b1;
        ser_bit    = dir_q ? sr_out[0] : sr_out[WIDTH-1];
      end
      RESP: begin
        bus.rsp_valid = !abort;
        bus.rsp_data  = sr_out;
      end
      default: begin
        sr_mode    = MODE_CLEAR;
        sr_data_in = '0;
      end
    endcase
  end

endmodule
